// File: rtl/sparse_conv_pe_stream.sv
// sparse_conv_pe_stream
//   Streaming sparse convolution PE. Accepts coordinate-tagged nonzero kernel
//   and feature beats and scatter-accumulates a stride-1 valid convolution into
//   an OUT_SIZE x OUT_SIZE accumulator array, summing over input channels.
//   It then drains the saturated map row-major on a valid/ready stream.
//
//   Optional build macro: SPARSE_PE_RELU_EN - clamps negative outputs to 0.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   w_valid/w_ready/w_value/w_row/w_col/w_last            weight stream
//   f_valid/f_ready/f_value/f_row/f_col/f_last/f_ch_last  feature stream
//   out_valid/out_ready/out_data/out_row/out_col/out_last output stream
//   busy                          low only when idle in LOAD_W with no weights
module sparse_conv_pe_stream #(
    parameter int WORD_LENGTH = 8,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int IDX_LENGTH  = 8,
    parameter int ACC_LENGTH  = 24,
    parameter int OUT_LENGTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [WORD_LENGTH-1:0] w_value,
    input  logic [IDX_LENGTH-1:0]  w_row,
    input  logic [IDX_LENGTH-1:0]  w_col,
    input  logic                   w_last,
    input  logic                   f_valid,
    output logic                   f_ready,
    input  logic [WORD_LENGTH-1:0] f_value,
    input  logic [IDX_LENGTH-1:0]  f_row,
    input  logic [IDX_LENGTH-1:0]  f_col,
    input  logic                   f_last,
    input  logic                   f_ch_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_LENGTH-1:0]  out_data,
    output logic [IDX_LENGTH-1:0]  out_row,
    output logic [IDX_LENGTH-1:0]  out_col,
    output logic                   out_last,
    output logic                   busy
);
    localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int KK       = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NACC     = OUT_SIZE * OUT_SIZE;
    localparam int AW       = $clog2(NACC);
    localparam int KIW      = $clog2(KK);
    localparam int WCW      = $clog2(KK + 1);
    localparam int PW       = 2 * WORD_LENGTH;

    localparam logic signed [ACC_LENGTH-1:0] SAT_HI = ACC_LENGTH'(2**(OUT_LENGTH-1) - 1);
    localparam logic signed [ACC_LENGTH-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {CLEAR, LOAD_W, LOAD_F, SCATTER, DRAIN} state_t;
    state_t state;

    // Storage without reset: reset never touches these, CLEAR/read-clear do.
    logic signed [WORD_LENGTH-1:0] wb_val [KK];
    logic [IDX_LENGTH-1:0]         wb_row [KK];
    logic [IDX_LENGTH-1:0]         wb_col [KK];
    logic signed [ACC_LENGTH-1:0]  acc    [NACC];

    logic [AW-1:0]                 ccnt, daddr;
    logic [WCW-1:0]                wcnt;
    logic [KIW-1:0]                sidx;
    logic [IDX_LENGTH-1:0]         drow, dcol;
    logic signed [WORD_LENGTH-1:0] fv_q;
    logic [IDX_LENGTH-1:0]         fr_q, fc_q;
    logic                          fl_q, fcl_q;

    function automatic logic [OUT_LENGTH-1:0] sat(input logic signed [ACC_LENGTH-1:0] a);
`ifdef SPARSE_PE_RELU_EN
        if (a[ACC_LENGTH-1]) return '0;
`endif
        if (a > SAT_HI) return SAT_HI[OUT_LENGTH-1:0];
        if (a < SAT_LO) return SAT_LO[OUT_LENGTH-1:0];
        return a[OUT_LENGTH-1:0];
    endfunction

    // Scatter datapath: one buffered weight against the latched feature.
    // Coordinates are zero-extended by one bit so the difference is signed.
    logic signed [IDX_LENGTH:0]   orow, ocol;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_LENGTH-1:0] prod_ext;
    logic [AW-1:0]                sc_addr;
    logic                         hit, sc_done;

    assign orow     = $signed({1'b0, fr_q}) - $signed({1'b0, wb_row[sidx]});
    assign ocol     = $signed({1'b0, fc_q}) - $signed({1'b0, wb_col[sidx]});
    assign prod     = fv_q * wb_val[sidx];
    assign prod_ext = {{(ACC_LENGTH-PW){prod[PW-1]}}, prod};
    assign sc_addr  = AW'(orow[IDX_LENGTH-1:0]) * AW'(OUT_SIZE) + AW'(ocol[IDX_LENGTH-1:0]);
    // Explicit coordinate bound checks: an out-of-kernel weight paired with an
    // out-of-image feature could otherwise land on a legal difference.
    assign hit = (wcnt != '0) && !orow[IDX_LENGTH] && !ocol[IDX_LENGTH]
              && (orow[IDX_LENGTH-1:0] < IDX_LENGTH'(OUT_SIZE))
              && (ocol[IDX_LENGTH-1:0] < IDX_LENGTH'(OUT_SIZE))
              && (wb_row[sidx] < IDX_LENGTH'(KERNEL_SIZE))
              && (wb_col[sidx] < IDX_LENGTH'(KERNEL_SIZE))
              && (fr_q < IDX_LENGTH'(IMAGE_SIZE)) && (fc_q < IDX_LENGTH'(IMAGE_SIZE));
    assign sc_done = (wcnt == '0) || (WCW'(sidx) == wcnt - 1'b1);

    // Drain read: the first DRAIN cycle (out_valid low) primes the current
    // location; after a handshake the next location is fetched.
    logic [AW-1:0]                rd_addr;
    logic signed [ACC_LENGTH-1:0] acc_rd;
    logic [IDX_LENGTH-1:0]        nrow, ncol;
    assign rd_addr = out_valid ? daddr + 1'b1 : daddr;
    assign acc_rd  = acc[rd_addr];
    assign nrow    = (dcol == IDX_LENGTH'(OUT_SIZE-1)) ? drow + 1'b1 : drow;
    assign ncol    = (dcol == IDX_LENGTH'(OUT_SIZE-1)) ? '0 : dcol + 1'b1;

    assign busy = !(state == LOAD_W && wcnt == '0);

    // Single accumulator write port shared by clear, scatter and read-clear.
    logic                         acc_we;
    logic [AW-1:0]                acc_wa;
    logic signed [ACC_LENGTH-1:0] acc_wd;
    always_comb begin
        acc_we = 1'b0;
        acc_wa = ccnt;
        acc_wd = '0;
        case (state)
            CLEAR:   acc_we = 1'b1;
            SCATTER: begin
                acc_we = hit;
                acc_wa = sc_addr;
                acc_wd = acc[sc_addr] + prod_ext;
            end
            DRAIN:   begin
                acc_we = out_valid && out_ready;
                acc_wa = daddr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc_we) acc[acc_wa] <= acc_wd;
        if (state == LOAD_W && w_valid && w_ready && wcnt < WCW'(KK)) begin
            wb_val[wcnt[KIW-1:0]] <= w_value;
            wb_row[wcnt[KIW-1:0]] <= w_row;
            wb_col[wcnt[KIW-1:0]] <= w_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            ccnt      <= '0;
            wcnt      <= '0;
            sidx      <= '0;
            daddr     <= '0;
            drow      <= '0;
            dcol      <= '0;
            fv_q      <= '0;
            fr_q      <= '0;
            fc_q      <= '0;
            fl_q      <= 1'b0;
            fcl_q     <= 1'b0;
            w_ready   <= 1'b0;
            f_ready   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    ccnt <= ccnt + 1'b1;
                    if (ccnt == AW'(NACC-1)) begin
                        ccnt    <= '0;
                        w_ready <= 1'b1;
                        state   <= LOAD_W;
                    end
                end
                LOAD_W: if (w_valid) begin
                    // Beats beyond buffer depth are accepted and dropped.
                    if (wcnt < WCW'(KK)) wcnt <= wcnt + 1'b1;
                    if (w_last) begin
                        w_ready <= 1'b0;
                        f_ready <= 1'b1;
                        state   <= LOAD_F;
                    end
                end
                LOAD_F: if (f_valid) begin
                    fv_q    <= f_value;
                    fr_q    <= f_row;
                    fc_q    <= f_col;
                    fl_q    <= f_last;
                    fcl_q   <= f_ch_last;
                    f_ready <= 1'b0;
                    sidx    <= '0;
                    state   <= SCATTER;
                end
                SCATTER: begin
                    sidx <= sidx + 1'b1;
                    if (sc_done) begin
                        if (!fl_q) begin
                            f_ready <= 1'b1;
                            state   <= LOAD_F;
                        end else if (!fcl_q) begin
                            wcnt    <= '0;
                            w_ready <= 1'b1;
                            state   <= LOAD_W;
                        end else begin
                            daddr <= '0;
                            drow  <= '0;
                            dcol  <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= sat(acc_rd);
                        out_row   <= drow;
                        out_col   <= dcol;
                        out_last  <= (daddr == AW'(NACC-1));
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            wcnt      <= '0;
                            w_ready   <= 1'b1;
                            state     <= LOAD_W;
                        end else begin
                            daddr    <= daddr + 1'b1;
                            drow     <= nrow;
                            dcol     <= ncol;
                            out_data <= sat(acc_rd);
                            out_row  <= nrow;
                            out_col  <= ncol;
                            out_last <= (daddr + 1'b1 == AW'(NACC-1));
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_conv_pe_stream.sv
// Directed bench for sparse_conv_pe_stream. Stimulus pushes a full expected
// 576-beat output map into a scoreboard queue; an independent monitor pops and
// compares every output handshake.
module tb_sparse_conv_pe_stream;
    localparam int OS = 24;
    localparam int N  = OS * OS;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_valid, w_ready, w_last;
    logic [7:0] w_value, w_row, w_col;
    logic       f_valid, f_ready, f_last, f_ch_last;
    logic [7:0] f_value, f_row, f_col;
    logic       out_valid, out_ready, out_last, busy;
    logic [7:0] out_data, out_row, out_col;

    sparse_conv_pe_stream dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_value(w_value),
        .w_row(w_row), .w_col(w_col), .w_last(w_last),
        .f_valid(f_valid), .f_ready(f_ready), .f_value(f_value),
        .f_row(f_row), .f_col(f_col), .f_last(f_last), .f_ch_last(f_ch_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int d; int r; int c; bit last; } beat_t;
    beat_t sb[$];
    int    em[N];
    int    tests  = 0;
    int    fails  = 0;
    int    nbeats = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a beat is taken on the next rising edge when valid&ready here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            beat_t e;
            int    d;
            d = int'($signed(out_data));
            nbeats++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected beat: got d=%0d r=%0d c=%0d", d, out_row, out_col);
            end else begin
                e = sb.pop_front();
                if (d != e.d || int'(out_row) != e.r || int'(out_col) != e.c || out_last != e.last) begin
                    fails++;
                    $display("FAIL beat(%0d,%0d): got d=%0d r=%0d c=%0d last=%0d expected d=%0d last=%0d",
                             e.r, e.c, d, out_row, out_col, out_last, e.d, e.last);
                end
            end
        end
    end

    task automatic clear_em();
        foreach (em[i]) em[i] = 0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) sb.push_back('{em[i], i / OS, i % OS, i == N - 1});
        clear_em();
    endtask

    task automatic send_w(input int v, input int r, input int c, input bit last);
        int t = 0;
        w_valid = 1'b1; w_value = 8'(v); w_row = 8'(r); w_col = 8'(c); w_last = last;
        @(negedge clk);
        while (!w_ready && t < 3000) begin @(negedge clk); t++; end
        chk("w_handshake", int'(w_ready), 1);
        @(posedge clk); #1;
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic send_f(input int v, input int r, input int c, input bit last, input bit chl);
        int t = 0;
        f_valid = 1'b1; f_value = 8'(v); f_row = 8'(r); f_col = 8'(c);
        f_last = last; f_ch_last = chl;
        @(negedge clk);
        while (!f_ready && t < 3000) begin @(negedge clk); t++; end
        chk("f_handshake", int'(f_ready), 1);
        @(posedge clk); #1;
        f_valid = 1'b0; f_last = 1'b0; f_ch_last = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 5000) begin @(posedge clk); #1; t++; end
        chk(name, sb.size(), 0);
    endtask

    // Called at posedge+1 right after rst falls; counts edges until w_ready.
    task automatic wait_clear(input string name);
        int t = 0;
        while (!w_ready && t < 2000) begin @(posedge clk); #1; t++; end
        chk(name, t, N);
    endtask

    task automatic wait_beats(input int target);
        int t = 0;
        while (nbeats < target && t < 5000) begin @(posedge clk); #1; t++; end
        chk("beat_wait", int'(nbeats >= target), 1);
    endtask

    task automatic frame_b();
        em[23*OS+23] = 6;
        push_frame();
        send_w(-2, 1, 2, 1'b0);
        send_w(2, 4, 4, 1'b1);
        send_f(7, 0, 0, 1'b0, 1'b0);
        send_f(3, 27, 27, 1'b1, 1'b1);
    endtask

    initial begin
        int ov_seen, base;
        rst = 1'b1; out_ready = 1'b0;
        w_valid = 0; w_value = 0; w_row = 0; w_col = 0; w_last = 0;
        f_valid = 0; f_value = 0; f_row = 0; f_col = 0; f_last = 0; f_ch_last = 0;
        clear_em();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 1);
        chk("rst_w_ready", int'(w_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        rst = 1'b0;

        // Reset then idle: CLEAR lasts 576 cycles.
        ov_seen = 0;
        for (int i = 1; i <= N; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen = 1;
            if (i == N - 1) chk("clear_w_ready_575", int'(w_ready), 0);
        end
        chk("clear_w_ready_576", int'(w_ready), 1);
        chk("idle_out_valid", ov_seen, 0);
        chk("idle_busy", int'(busy), 0);
        out_ready = 1'b1;

        // Single tap.
        em[3*OS+4] = 5;
        push_frame();
        send_w(1, 0, 0, 1'b1);
        send_f(5, 3, 4, 1'b1, 1'b1);
        wait_drain("drain_single");

        // Edge coordinates.
        frame_b();
        wait_drain("drain_edges");

        // Positive saturation over two channels.
        em[0] = 127;
        push_frame();
        send_w(127, 0, 0, 1'b1);
        send_f(127, 0, 0, 1'b1, 1'b0);
        send_w(127, 0, 0, 1'b1);
        send_f(127, 0, 0, 1'b1, 1'b1);
        wait_drain("drain_sat_pos");

        // Negative saturation.
`ifdef SPARSE_PE_RELU_EN
        em[0] = 0;
`else
        em[0] = -128;
`endif
        push_frame();
        send_w(-128, 0, 0, 1'b1);
        send_f(127, 0, 0, 1'b1, 1'b1);
        wait_drain("drain_sat_neg");

        // Backpressure at beat 100 (row 4, col 4).
        em[100] = 9;
        push_frame();
        base = nbeats;
        send_w(1, 0, 0, 1'b1);
        send_f(9, 4, 4, 1'b1, 1'b1);
        wait_beats(base + 100);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'($signed(out_data)), 9);
            chk("stall_row", int'(out_row), 4);
            chk("stall_col", int'(out_col), 4);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("drain_backpressure");

        // Read-clear: the previous 9 must be gone.
        em[5*OS+5] = 2;
        push_frame();
        send_w(1, 0, 0, 1'b1);
        send_f(2, 5, 5, 1'b1, 1'b1);
        wait_drain("drain_readclear");

        // Reset mid-SCATTER.
        for (int i = 0; i < 5; i++) send_w(3, i, i, i == 4);
        send_f(3, 10, 10, 1'b1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("scat_rst_w_ready", int'(w_ready), 0);
        chk("scat_rst_f_ready", int'(f_ready), 0);
        chk("scat_rst_out_valid", int'(out_valid), 0);
        chk("scat_rst_busy", int'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_clear("scat_rst_clear_len");
        frame_b();
        wait_drain("drain_after_scat_rst");

        // Reset mid-DRAIN with a nonzero beyond the abort point.
        em[20*OS+20] = 4;
        push_frame();
        base = nbeats;
        send_w(1, 0, 0, 1'b1);
        send_f(4, 20, 20, 1'b1, 1'b1);
        wait_beats(base + 50);
        #1;
        rst = 1'b1;
        #1;
        chk("drain_rst_out_valid", int'(out_valid), 0);
        chk("drain_rst_out_last", int'(out_last), 0);
        chk("drain_rst_w_ready", int'(w_ready), 0);
        chk("drain_rst_busy", int'(busy), 1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_clear("drain_rst_clear_len");
        frame_b();
        wait_drain("drain_after_drain_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
